// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared types and helpers for the memory access controller
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAR,
        ACCESS,
        CAPTURE,
        DONE,
        ALIGN_ERR
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    // Reserved size (11) is always treated as misaligned so it never reaches RAM
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = a[0];
            SZ_WORD: m = (a != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - requester, MAR/MDR and RAM handshake bundle
interface mem_access_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic        ram_moc;
    logic        mar_ld;
    logic [31:0] mar_d;
    logic        mdr_ld;
    logic        ram_mfa;
    logic        ram_rw;
    logic [1:0]  ram_size;
    logic        if_gnt;
    logic        d_gnt;
    logic        if_done;
    logic        d_done;
    logic        err_timeout;
    logic        err_align;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, ram_moc,
        output mar_ld, mar_d, mdr_ld, ram_mfa, ram_rw, ram_size,
               if_gnt, d_gnt, if_done, d_done, err_timeout, err_align, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, ram_moc,
        input  mar_ld, mar_d, mdr_ld, ram_mfa, ram_rw, ram_size,
               if_gnt, d_gnt, if_done, d_done, err_timeout, err_align, busy
    );
endinterface

// File: rtl/mem_access_ctrl_rr_arbiter2.sv
// rtl/mem_access_ctrl_rr_arbiter2.sv - two-input round-robin arbiter, one-hot winner
module rr_arbiter2
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_if,
    input  logic       req_d,
    input  logic       upd,
    input  owner_e     upd_owner,
    output logic [1:0] win
);

    owner_e rr_last;

    // Remember who was served last; starting at DATA lets fetch win the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= OWN_D;
        end else if (upd) begin
            rr_last <= upd_owner;
        end
    end

    // win[0] = fetch, win[1] = data; on a tie the one not served last wins
    always_comb begin
        win = 2'b00;
        if (req_if && (!req_d || rr_last == OWN_D)) begin
            win[0] = 1'b1;
        end else if (req_d) begin
            win[1] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MAR/MDR/RAM transaction sequencer with arbitration and timeout
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_ctrl_if.slave   bus
);

    state_e             state, state_n;
    owner_e             owner_q, sel_owner;
    logic               we_q, sel_we;
    logic [1:0]         size_q, sel_size;
    logic [31:0]        mar_d_q, sel_addr;
    logic [CNT_W-1:0]   cnt;
    logic               to_q;
    logic [1:0]         win;
    logic               mis, cnt_hit, upd;

    logic mar_ld, mdr_ld, ram_mfa, ram_rw;
    logic [1:0] ram_size;
    logic if_gnt, d_gnt, if_done, d_done, err_timeout, err_align;

    // A misaligned request still ends the owner's turn so it cannot starve the other side
    assign upd = (state == DONE) || (state == ALIGN_ERR);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (bus.if_req),
        .req_d     (bus.d_req),
        .upd       (upd),
        .upd_owner (owner_q),
        .win       (win)
    );

    // Pick the winning request's attributes; a fetch is always a word read
    always_comb begin
        sel_owner = OWN_D;
        sel_addr  = bus.d_addr;
        sel_size  = bus.d_size;
        sel_we    = bus.d_we;
        if (win[0]) begin
            sel_owner = OWN_IF;
            sel_addr  = bus.if_addr;
            sel_size  = SZ_WORD;
            sel_we    = 1'b0;
        end
    end

    assign mis     = is_misaligned(sel_size, sel_addr[1:0]);
    assign cnt_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Latch the winner; mar_d only changes when a real RAM access is starting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            mar_d_q <= '0;
        end else if (state == IDLE && win != 2'b00) begin
            owner_q <= sel_owner;
            we_q    <= sel_we;
            size_q  <= sel_size;
            if (!mis) begin
                mar_d_q <= sel_addr;
            end
        end
    end

    // Timeout counter and sticky timeout flag, both restarted for each access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            to_q <= 1'b0;
        end else if (state == LOAD_MAR) begin
            cnt  <= '0;
            to_q <= 1'b0;
        end else if (state == ACCESS) begin
            cnt <= cnt + 1'b1;
            if (!bus.ram_moc && cnt_hit) begin
                to_q <= 1'b1;
            end
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_n     = state;
        mar_ld      = 1'b0;
        mdr_ld      = 1'b0;
        ram_mfa     = 1'b0;
        ram_rw      = 1'b0;
        ram_size    = 2'b00;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        if_done     = 1'b0;
        d_done      = 1'b0;
        err_timeout = 1'b0;
        err_align   = 1'b0;
        case (state)
            IDLE: begin
                if (win != 2'b00) begin
                    state_n = mis ? ALIGN_ERR : LOAD_MAR;
                end
            end
            LOAD_MAR: begin
                mar_ld  = 1'b1;
                if_gnt  = (owner_q == OWN_IF);
                d_gnt   = (owner_q == OWN_D);
                state_n = ACCESS;
            end
            ACCESS: begin
                ram_mfa  = 1'b1;
                ram_rw   = !we_q;
                ram_size = size_q;
                if (bus.ram_moc) begin
                    state_n = we_q ? DONE : CAPTURE;
                end else if (cnt_hit) begin
                    state_n = DONE;
                end
            end
            CAPTURE: begin
                mdr_ld   = 1'b1;
                ram_mfa  = 1'b1;
                ram_rw   = !we_q;
                ram_size = size_q;
                state_n  = DONE;
            end
            DONE: begin
                if_done     = (owner_q == OWN_IF);
                d_done      = (owner_q == OWN_D);
                err_timeout = to_q;
                state_n     = IDLE;
            end
            ALIGN_ERR: begin
                if_gnt    = (owner_q == OWN_IF);
                d_gnt     = (owner_q == OWN_D);
                if_done   = (owner_q == OWN_IF);
                d_done    = (owner_q == OWN_D);
                err_align = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.mar_ld      = mar_ld;
    assign bus.mar_d       = mar_d_q;
    assign bus.mdr_ld      = mdr_ld;
    assign bus.ram_mfa     = ram_mfa;
    assign bus.ram_rw      = ram_rw;
    assign bus.ram_size    = ram_size;
    assign bus.if_gnt      = if_gnt;
    assign bus.d_gnt       = d_gnt;
    assign bus.if_done     = if_done;
    assign bus.d_done      = d_done;
    assign bus.err_timeout = err_timeout;
    assign bus.err_align   = err_align;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    typedef struct {
        bit own_d;
        bit al;
        bit to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t sb[$];
    bit   gnt_q[$];

    int          t_gnt, t_mar, t_mdr, t_done, t_moc;
    int          n_mfa, n_mdr, n_marld;
    logic [31:0] mar_val;
    logic        rw_seen, e_al, e_to;
    logic [1:0]  size_seen;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {bus.mar_ld, bus.mdr_ld, bus.ram_mfa, bus.ram_rw, bus.ram_size,
                bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done,
                bus.err_timeout, bus.err_align, bus.busy};
    endfunction

    task automatic push_exp(input bit own_d, input bit al, input bit to);
        exp_t e;
        e.own_d = own_d;
        e.al    = al;
        e.to    = to;
        sb.push_back(e);
        gnt_q.push_back(own_d);
    endtask

    // Follow one transaction to its done pulse, answering MOC in ACCESS cycle moc_k (0 = never)
    task automatic watch(input int moc_k, input bit keep, input int budget);
        int   acc = 0;
        bit   got = 0;
        bit   viol = 0;
        exp_t e;
        t_gnt = -1; t_mar = -1; t_mdr = -1; t_done = -1; t_moc = -1;
        n_mfa = 0; n_mdr = 0; n_marld = 0;
        mar_val = '0; rw_seen = 1'bx; size_seen = 2'bxx;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.if_gnt && bus.d_gnt) viol = 1;
            if (bus.if_done && bus.d_done) viol = 1;
            if (bus.if_gnt || bus.d_gnt) begin
                t_gnt = cyc;
                chk("gnt_q_depth", gnt_q.size(), 1);
                if (gnt_q.size() != 0) chk("gnt_owner", bus.d_gnt, gnt_q.pop_front());
                if (!keep) begin
                    if (bus.if_gnt) bus.if_req = 1'b0;
                    if (bus.d_gnt)  bus.d_req  = 1'b0;
                end
            end
            if (bus.mar_ld) begin
                n_marld++;
                t_mar   = cyc;
                mar_val = bus.mar_d;
            end
            if (bus.ram_mfa) begin
                n_mfa++;
                if (n_mfa == 1) begin
                    rw_seen   = bus.ram_rw;
                    size_seen = bus.ram_size;
                end
                if (!bus.mdr_ld) acc++;
            end
            if (bus.mdr_ld) begin
                n_mdr++;
                t_mdr = cyc;
            end
            bus.ram_moc = (moc_k != 0 && bus.ram_mfa && !bus.mdr_ld && acc == moc_k);
            if (bus.ram_moc) t_moc = cyc;
            if (bus.if_done || bus.d_done) begin
                got    = 1;
                t_done = cyc;
                e_al   = bus.err_align;
                e_to   = bus.err_timeout;
                chk("sb_depth", sb.size(), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_owner", bus.d_done, e.own_d);
                    chk("done_err_align", bus.err_align, e.al);
                    chk("done_err_timeout", bus.err_timeout, e.to);
                end
            end
        end
        chk("done_seen", got, 1);
        chk("gnt_done_onehot", viol, 0);
    endtask

    initial begin
        int n0;
        int mfa_cnt;
        int dones;

        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_size = '0; bus.d_addr = '0; bus.ram_moc = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs(), 13'h0);
        chk("reset_mar_d", bus.mar_d, 32'h0);
        rst_n = 1'b1;

        // Fetch read, MOC in first ACCESS cycle
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h0000_0040;
        n0 = cyc;
        push_exp(0, 0, 0);
        watch(1, 0, 40);
        chk("fetch_gnt_lat", t_gnt, n0 + 1);
        chk("fetch_mar_lat", t_mar, n0 + 1);
        chk("fetch_mar_d", mar_val, 32'h40);
        chk("fetch_mdr_lat", t_mdr, n0 + 3);
        chk("fetch_done_lat", t_done, n0 + 4);
        chk("fetch_rw", rw_seen, 1);
        chk("fetch_size", size_seen, 2'b10);

        // Halfword store, MOC after three waiting cycles
        @(posedge clk); #1;
        bus.d_req = 1; bus.d_we = 1; bus.d_size = 2'b01; bus.d_addr = 32'h0000_0102;
        push_exp(1, 0, 0);
        watch(4, 0, 40);
        chk("store_rw", rw_seen, 0);
        chk("store_size", size_seen, 2'b01);
        chk("store_no_mdr", n_mdr, 0);
        chk("store_mfa_cycles", n_mfa, 4);
        chk("store_done_after_moc", t_done, t_moc + 1);
        chk("store_mar_d", mar_val, 32'h102);

        // Contention: both held for four transactions, grants alternate IF, D, IF, D
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h0000_0200;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h0000_0300;
        for (int k = 0; k < 4; k++) begin
            push_exp(k[0], 0, 0);
            watch(1, 1, 40);
            chk("contend_mar_d", mar_val, k[0] ? 32'h300 : 32'h200);
        end
        bus.if_req = 0; bus.d_req = 0;

        // Misaligned word load
        @(posedge clk); #1;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h0000_0006;
        push_exp(1, 1, 0);
        watch(0, 0, 20);
        chk("align_gnt_with_done", t_gnt, t_done);
        chk("align_no_mar_ld", n_marld, 0);
        chk("align_no_mfa", n_mfa, 0);

        // MOC while idle is ignored
        @(posedge clk); #1;
        bus.ram_moc = 1;
        repeat (3) @(negedge clk);
        chk("idle_moc_busy", bus.busy, 0);
        chk("idle_moc_done", {bus.if_done, bus.d_done}, 2'b00);
        bus.ram_moc = 0;

        // Timeout: no MOC at all
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h0000_0080;
        push_exp(0, 0, 1);
        watch(0, 0, 60);
        chk("timeout_mfa_cycles", n_mfa, 16);
        chk("timeout_no_mdr", n_mdr, 0);

        // Reset during the second ACCESS cycle
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h0000_0100;
        mfa_cnt = 0;
        dones = 0;
        for (int i = 0; i < 10 && mfa_cnt < 2; i++) begin
            @(negedge clk);
            if (bus.if_gnt) bus.if_req = 0;
            if (bus.ram_mfa) mfa_cnt++;
            if (bus.if_done || bus.d_done) dones++;
        end
        chk("abort_reached_access", mfa_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", all_outs(), 13'h0);
        chk("abort_mar_d", bus.mar_d, 32'h0);
        bus.if_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.if_done || bus.d_done) dones++;
        end
        chk("abort_no_done", dones, 0);

        // Fresh fetch after reset completes normally
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h0000_0044;
        n0 = cyc;
        push_exp(0, 0, 0);
        watch(1, 0, 40);
        chk("post_rst_mar_d", mar_val, 32'h44);
        chk("post_rst_done_lat", t_done, n0 + 4);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
